// File: rtl/vga_region_ctrl.sv
// VGA timing generator with a register-programmed background and NUM_REGIONS priority rectangles.
// Define VGA_SHADOW_EN to stage register writes in shadow copies that commit once per frame.
module vga_region_ctrl #(
    parameter int CLK_DIV     = 4,
    parameter int H_VIS       = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VIS       = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int NUM_REGIONS = 4,
    parameter int SYNC_POL    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic        read,
    input  logic [11:0] address,
    input  logic [11:0] data,
    output logic [11:0] rdata,
    output logic        Hsync,
    output logic        Vsync,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue,
    output logic        vblank,
    output logic        frame_irq
);
    localparam int   HT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int   VT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int   HV0   = H_SYNC + H_BP;
    localparam int   VV0   = V_SYNC + V_BP;
    localparam int   DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic SP    = 1'(SYNC_POL);

    // ---------------- timing ----------------
    logic [DIV_W-1:0] div_q;
    logic [10:0]      hcnt_q, vcnt_q;
    logic [10:0]      frame_q;
    logic             pix_en, h_last, v_last, commit;

    assign pix_en = (div_q == DIV_W'(CLK_DIV - 1));
    assign h_last = (hcnt_q == 11'(HT - 1));
    assign v_last = (vcnt_q == 11'(VT - 1));
    assign commit = pix_en && h_last && v_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            frame_q <= '0;
        end else begin
            div_q <= pix_en ? '0 : div_q + 1'b1;
            if (pix_en) begin
                if (h_last) begin
                    hcnt_q <= '0;
                    vcnt_q <= v_last ? '0 : vcnt_q + 11'd1;
                end else begin
                    hcnt_q <= hcnt_q + 11'd1;
                end
            end
            if (commit)
                frame_q <= frame_q + 11'd1;
        end
    end

    // ---------------- register file ----------------
    logic [11:0] bg_q, bg_d, cur_bg;
    logic        en_q, en_d, cur_en;
    logic [11:0] col_q [NUM_REGIONS];
    logic [11:0] x0_q  [NUM_REGIONS];
    logic [11:0] x1_q  [NUM_REGIONS];
    logic [11:0] y0_q  [NUM_REGIONS];
    logic [11:0] y1_q  [NUM_REGIONS];
    logic [11:0] col_d [NUM_REGIONS];
    logic [11:0] x0_d  [NUM_REGIONS];
    logic [11:0] x1_d  [NUM_REGIONS];
    logic [11:0] y0_d  [NUM_REGIONS];
    logic [11:0] y1_d  [NUM_REGIONS];
    logic [11:0] cur_col [NUM_REGIONS];
    logic [11:0] cur_x0  [NUM_REGIONS];
    logic [11:0] cur_x1  [NUM_REGIONS];
    logic [11:0] cur_y0  [NUM_REGIONS];
    logic [11:0] cur_y1  [NUM_REGIONS];

`ifdef VGA_SHADOW_EN
    logic [11:0] sh_bg_q;
    logic        sh_en_q;
    logic [11:0] sh_col_q [NUM_REGIONS];
    logic [11:0] sh_x0_q  [NUM_REGIONS];
    logic [11:0] sh_x1_q  [NUM_REGIONS];
    logic [11:0] sh_y0_q  [NUM_REGIONS];
    logic [11:0] sh_y1_q  [NUM_REGIONS];
    // Host-visible copy is the shadow set; the active set only follows it at commit.
    assign cur_bg  = sh_bg_q;
    assign cur_en  = sh_en_q;
    assign cur_col = sh_col_q;
    assign cur_x0  = sh_x0_q;
    assign cur_x1  = sh_x1_q;
    assign cur_y0  = sh_y0_q;
    assign cur_y1  = sh_y1_q;
`else
    assign cur_bg  = bg_q;
    assign cur_en  = en_q;
    assign cur_col = col_q;
    assign cur_x0  = x0_q;
    assign cur_x1  = x1_q;
    assign cur_y0  = y0_q;
    assign cur_y1  = y1_q;
`endif

    logic       in_rgn;
    logic [3:0] ridx;
    assign in_rgn = (address >= 12'h010) && (address < 12'(16 + 8 * NUM_REGIONS))
                    && (address[2:0] <= 3'd4);
    assign ridx   = 4'(address[7:3] - 5'd2);

    always_comb begin
        bg_d  = cur_bg;
        en_d  = cur_en;
        col_d = cur_col;
        x0_d  = cur_x0;
        x1_d  = cur_x1;
        y0_d  = cur_y0;
        y1_d  = cur_y1;
        if (write) begin
            if (address == 12'h000) bg_d = data;
            if (address == 12'h001) en_d = data[0];
            for (int n = 0; n < NUM_REGIONS; n++) begin
                if (in_rgn && ridx == 4'(n)) begin
                    case (address[2:0])
                        3'd0:    col_d[n] = data;
                        3'd1:    x0_d[n]  = data;
                        3'd2:    x1_d[n]  = data;
                        3'd3:    y0_d[n]  = data;
                        default: y1_d[n]  = data;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bg_q <= 12'hFFF;
            en_q <= 1'b1;
            for (int n = 0; n < NUM_REGIONS; n++) begin
                col_q[n] <= '0;
                x0_q[n]  <= '0;
                x1_q[n]  <= '0;
                y0_q[n]  <= '0;
                y1_q[n]  <= '0;
            end
`ifdef VGA_SHADOW_EN
            sh_bg_q <= 12'hFFF;
            sh_en_q <= 1'b1;
            for (int n = 0; n < NUM_REGIONS; n++) begin
                sh_col_q[n] <= '0;
                sh_x0_q[n]  <= '0;
                sh_x1_q[n]  <= '0;
                sh_y0_q[n]  <= '0;
                sh_y1_q[n]  <= '0;
            end
`endif
        end else begin
`ifdef VGA_SHADOW_EN
            sh_bg_q  <= bg_d;
            sh_en_q  <= en_d;
            sh_col_q <= col_d;
            sh_x0_q  <= x0_d;
            sh_x1_q  <= x1_d;
            sh_y0_q  <= y0_d;
            sh_y1_q  <= y1_d;
            // Commit takes the write-merged shadow so a commit-clk write lands this frame.
            if (commit) begin
                bg_q  <= bg_d;
                en_q  <= en_d;
                col_q <= col_d;
                x0_q  <= x0_d;
                x1_q  <= x1_d;
                y0_q  <= y0_d;
                y1_q  <= y1_d;
            end
`else
            bg_q  <= bg_d;
            en_q  <= en_d;
            col_q <= col_d;
            x0_q  <= x0_d;
            x1_q  <= x1_d;
            y0_q  <= y0_d;
            y1_q  <= y1_d;
`endif
        end
    end

    // ---------------- read port ----------------
    logic [11:0] rd_val;
    always_comb begin
        rd_val = '0;
        case (address)
            12'h000: rd_val = cur_bg;
            12'h001: rd_val = {11'd0, cur_en};
            12'h002: rd_val = {frame_q, vblank};
            default: begin
                for (int n = 0; n < NUM_REGIONS; n++) begin
                    if (in_rgn && ridx == 4'(n)) begin
                        case (address[2:0])
                            3'd0:    rd_val = cur_col[n];
                            3'd1:    rd_val = cur_x0[n];
                            3'd2:    rd_val = cur_x1[n];
                            3'd3:    rd_val = cur_y0[n];
                            default: rd_val = cur_y1[n];
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            rdata <= '0;
        else if (read)
            rdata <= rd_val;
    end

    // ---------------- pixel pipeline ----------------
    logic [10:0] x, y;
    logic        h_vis, v_vis;
    logic [NUM_REGIONS-1:0] hit;
    logic [11:0] pix_col;

    assign h_vis = (hcnt_q >= 11'(HV0)) && (hcnt_q < 11'(HV0 + H_VIS));
    assign v_vis = (vcnt_q >= 11'(VV0)) && (vcnt_q < 11'(VV0 + V_VIS));
    assign x     = hcnt_q - 11'(HV0);
    assign y     = vcnt_q - 11'(VV0);

    // Half-open bounds make X1<=X0 or Y1<=Y0 an empty rectangle with no extra logic.
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_rgn
        assign hit[gi] = ({1'b0, x} >= x0_q[gi]) && ({1'b0, x} < x1_q[gi])
                      && ({1'b0, y} >= y0_q[gi]) && ({1'b0, y} < y1_q[gi]);
    end

    always_comb begin
        pix_col = bg_q;
        for (int n = NUM_REGIONS - 1; n >= 0; n--)
            if (hit[n]) pix_col = col_q[n];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Hsync     <= ~SP;
            Vsync     <= ~SP;
            Red       <= '0;
            Green     <= '0;
            Blue      <= '0;
            vblank    <= 1'b1;
            frame_irq <= 1'b0;
        end else begin
            Hsync     <= (hcnt_q < 11'(H_SYNC)) ? SP : ~SP;
            Vsync     <= (vcnt_q < 11'(V_SYNC)) ? SP : ~SP;
            vblank    <= ~v_vis;
            frame_irq <= commit;
            if (h_vis && v_vis && en_q) begin
                Red   <= pix_col[3:0];
                Green <= pix_col[7:4];
                Blue  <= pix_col[11:8];
            end else begin
                Red   <= '0;
                Green <= '0;
                Blue  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_region_ctrl.sv
// Directed bench for vga_region_ctrl on a reduced 50x19-pixel raster (CLK_DIV=4, 3800 clks/frame).
// Expectations for shadowed behaviour switch on VGA_SHADOW_EN.
module tb_vga_region_ctrl;
    localparam int CLK_DIV = 4;
    localparam int HT = 32 + 4 + 8 + 6;       // 50
    localparam int VT = 12 + 2 + 2 + 3;       // 19
    localparam int F  = HT * VT * CLK_DIV;    // 3800

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [11:0] address = '0;
    logic [11:0] data = '0;
    logic [11:0] rdata;
    logic        Hsync, Vsync, vblank, frame_irq;
    logic [3:0]  Red, Green, Blue;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    vga_region_ctrl #(
        .CLK_DIV(CLK_DIV), .H_VIS(32), .H_FP(4), .H_SYNC(8), .H_BP(6),
        .V_VIS(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .NUM_REGIONS(4), .SYNC_POL(1)
    ) dut (
        .clk(clk), .reset(reset), .write(write), .read(read), .address(address),
        .data(data), .rdata(rdata), .Hsync(Hsync), .Vsync(Vsync), .Red(Red),
        .Green(Green), .Blue(Blue), .vblank(vblank), .frame_irq(frame_irq)
    );

    always #5 clk = ~clk;

    // Clocks since reset release; after edge k the outputs reflect pixel (k-1)/4.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [11:0] rgb();
        return {Blue, Green, Red};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [11:0] d);
        address = a; data = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        $display("WR  addr=%h data=%h cyc=%0d", a, d, cyc);
    endtask

    task automatic rd(input logic [11:0] a, output logic [11:0] v);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        v = rdata;
        $display("RD  addr=%h data=%h cyc=%0d", a, v, cyc);
    endtask

    task automatic wait_pix(input int h, input int v);
        int t;
        int n;
        t = v * HT + h;
        n = 0;
        while (!(cyc >= 1 && ((cyc - 1) % F) == 4 * t) && n <= F + 8) begin
            @(negedge clk);
            n++;
        end
        if (n > F + 8) begin
            failures++;
            $error("FAIL wait_pix timeout observed=%0d expected=%0d", cyc, 4 * t);
        end
    endtask

    task automatic wait_mod(input int r);
        int n;
        n = 0;
        while (!(cyc > 0 && (cyc % F) == r) && n <= F + 8) begin
            @(negedge clk);
            n++;
        end
        if (n > F + 8) begin
            failures++;
            $error("FAIL wait_mod timeout observed=%0d expected=%0d", cyc % F, r);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hsync"}, {11'd0, Hsync}, 12'h000);
        chk({tag, "_vsync"}, {11'd0, Vsync}, 12'h000);
        chk({tag, "_vblank"}, {11'd0, vblank}, 12'h001);
        chk({tag, "_rgb"}, rgb(), 12'h000);
        chk({tag, "_irq"}, {11'd0, frame_irq}, 12'h000);
        chk({tag, "_rdata"}, rdata, 12'h000);
    endtask

    initial begin
        logic [11:0] v;
        int hs;

        repeat (3) @(negedge clk);
        chk_reset_outputs("por");

        // Release and measure one full line of Hsync.
        reset = 1'b0;
        hs = 0;
        for (int i = 0; i < HT * CLK_DIV; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("first_hsync", {11'd0, Hsync}, 12'h001);
                chk("first_vsync", {11'd0, Vsync}, 12'h001);
            end
            if (Hsync) hs++;
        end
        chk("hsync_clks_per_line", 12'(hs), 12'd32);

        rd(12'h000, v); chk("bg_default", v, 12'hFFF);
        rd(12'h001, v); chk("ctrl_default", v, 12'h001);
        rd(12'h010, v); chk("r0_col_default", v, 12'h000);
        rd(12'h014, v); chk("r0_y1_default", v, 12'h000);

        // Visible window boundaries in frame 0.
        wait_pix(20, 4);  chk("vblank_v4", {11'd0, vblank}, 12'h001);
        wait_pix(13, 5);  chk("pix_before_vis", rgb(), 12'h000);
        wait_pix(14, 5);  chk("first_vis_pix", rgb(), 12'hFFF);
                          chk("vblank_v5", {11'd0, vblank}, 12'h000);
        wait_pix(45, 5);  chk("last_vis_pix", rgb(), 12'hFFF);
        wait_pix(46, 5);  chk("pix_after_vis", rgb(), 12'h000);
        wait_pix(20, 17); rd(12'h002, v); chk("status_f0_blank", v, 12'h001);

        // Region 0: red rectangle x 10..19, y 5.
        wr(12'h010, 12'h00F); wr(12'h011, 12'd10); wr(12'h012, 12'd20);
        wr(12'h013, 12'd5);   wr(12'h014, 12'd6);

        wait_mod(0);
        chk("frame_irq_pulse", {11'd0, frame_irq}, 12'h001);
        @(negedge clk);
        chk("frame_irq_one_clk", {11'd0, frame_irq}, 12'h000);

        wait_pix(24, 9);  chk("r0_y4", rgb(), 12'hFFF);
        wait_pix(23, 10); chk("r0_x9", rgb(), 12'hFFF);
        wait_pix(24, 10); chk("r0_x10", rgb(), 12'h00F);
        wait_pix(33, 10); chk("r0_x19", rgb(), 12'h00F);
        wait_pix(34, 10); chk("r0_x20", rgb(), 12'hFFF);
        wait_pix(24, 11); chk("r0_y6", rgb(), 12'hFFF);
        wait_pix(40, 12); rd(12'h002, v); chk("status_f1_vis", v, 12'h002);

        // Region 1 overlapping region 0 at x 15..19.
        wr(12'h018, 12'h0F0); wr(12'h019, 12'd15); wr(12'h01A, 12'd25);
        wr(12'h01B, 12'd5);   wr(12'h01C, 12'd6);
        wait_pix(29, 10); chk("overlap_low_wins", rgb(), 12'h00F);
        wait_pix(36, 10); chk("r1_only", rgb(), 12'h0F0);
        wait_pix(40, 12); wr(12'h012, 12'd10);
        wait_pix(26, 10); chk("r0_empty_bg", rgb(), 12'hFFF);
        wait_pix(29, 10); chk("overlap_r1_after_empty", rgb(), 12'h0F0);

        rd(12'h012, v); chk("r0_x1_readback", v, 12'h00A);
        rd(12'h000, v); chk("bg_readback", v, 12'hFFF);
        rd(12'h7FF, v); chk("unmapped_7ff", v, 12'h000);
        rd(12'h015, v); chk("unmapped_offset5", v, 12'h000);
        wr(12'h030, 12'h555);
        rd(12'h030, v); chk("region4_ignored", v, 12'h000);
        wr(12'h002, 12'hAAA);
        wait_pix(40, 13); rd(12'h002, v); chk("status_f3_ro", v, 12'h006);
        repeat (5) @(negedge clk);
        chk("rdata_hold", rdata, 12'h006);

        // Display disable blanks RGB but keeps sync.
        wr(12'h001, 12'h000);
        rd(12'h001, v); chk("ctrl_readback", v, 12'h000);
        wait_pix(2, 1);   chk("hsync_ctrl_off", {11'd0, Hsync}, 12'h001);
                          chk("vsync_ctrl_off", {11'd0, Vsync}, 12'h001);
        wait_pix(20, 8);  chk("rgb_ctrl_off", rgb(), 12'h000);
        wr(12'h001, 12'h001);

        // Simultaneous read and write of BG returns the old value.
        address = 12'h000; data = 12'h123; write = 1'b1; read = 1'b1;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        chk("rw_same_old", rdata, 12'hFFF);
        rd(12'h000, v); chk("rw_same_new", v, 12'h123);
        wr(12'h000, 12'hFFF);

        // BG change mid-frame.
        wait_mod(0);
        wait_pix(5, 12);
        wr(12'h000, 12'h000);
        rd(12'h000, v); chk("bg_read_immediate", v, 12'h000);
        wait_pix(40, 14);
`ifdef VGA_SHADOW_EN
        chk("bg_same_frame", rgb(), 12'hFFF);
`else
        chk("bg_same_frame", rgb(), 12'h000);
`endif
        wait_pix(40, 14); chk("bg_next_frame", rgb(), 12'h000);

        // Write landing on the commit clk.
        wait_mod(F - 1);
        wr(12'h000, 12'h0A5);
        wait_pix(40, 14); chk("commit_clk_write", rgb(), 12'h0A5);

        // Mid-frame reset.
        wait_pix(10, 8);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("mid");
        reset = 1'b0;
        @(negedge clk);
        chk("restart_hsync", {11'd0, Hsync}, 12'h001);
        chk("restart_vsync", {11'd0, Vsync}, 12'h001);
        rd(12'h000, v); chk("reset_bg", v, 12'hFFF);
        rd(12'h011, v); chk("reset_r0_x0", v, 12'h000);
        rd(12'h002, v); chk("reset_status", v, 12'h001);
        wait_pix(24, 10); chk("reset_regions_cleared", rgb(), 12'hFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
